// File: rtl/eth_tx_sched_pkg.sv
// Shared types and source indices for the Ethernet TX frame scheduler.
// No logic; no latency or backpressure of its own.
package eth_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } tx_sched_state_t;

  localparam int SRC_ARP_RESP = 0;
  localparam int SRC_ICMP     = 1;
  localparam int SRC_ARP_REQ  = 2;
  localparam int SRC_UDP      = 3;
  localparam int NUM_SRC      = 4;

endpackage

// File: rtl/eth_tx_sched_if.sv
// Request/grant bundle between the frame sources, the scheduler and the TX engine.
// Pulses only: sources cannot be backpressured, requests are latched by the scheduler.
interface eth_tx_sched_if;
  import eth_tx_sched_pkg::*;

  logic [NUM_SRC-1:0] req_pulse;
  logic               tx_done;
  logic               tx_start;
  logic [1:0]         tx_sel;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] pending;
  logic               busy;
  logic               timeout_err;

  modport master (
    input  req_pulse, tx_done,
    output tx_start, tx_sel, grant, pending, busy, timeout_err
  );

  modport slave (
    output req_pulse, tx_done,
    input  tx_start, tx_sel, grant, pending, busy, timeout_err
  );
endinterface

// File: rtl/eth_tx_sched_prio.sv
// Fixed-priority pick (bit 0 highest) with a UDP anti-starvation override.
// Purely combinational, zero latency; no backpressure.
module eth_tx_sched_prio
  import eth_tx_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] pending,
  input  logic               force_udp,
  output logic [1:0]         win_idx,
  output logic               win_vld
);

  always_comb begin
    win_idx = 2'(SRC_ARP_RESP);
    win_vld = |pending;
    if (force_udp) begin
      win_idx = 2'(SRC_UDP);
    end else begin
      // Descending scan so the lowest set index is the one left standing.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (pending[i]) win_idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Grants the single TX engine to one of four latched frame requests, with IFG and watchdog.
// Request-to-tx_start latency 2 cycles when idle; sources are never stalled, repeats coalesce.
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_SKIP       = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  eth_tx_sched_if.master  sif
);

  localparam int SKW = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam int GW  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  tx_sched_state_t    state;
  logic [NUM_SRC-1:0] pending_q, grant_q, win_oh;
  logic [1:0]         tx_sel_q, win_idx;
  logic               win_vld, force_udp, do_grant, wd_exp;
  logic               tx_start_q, busy_q, timeout_q;
  logic [SKW-1:0]     skip_cnt;
  logic [TW-1:0]      to_cnt;
  logic [GW-1:0]      gap_cnt;

  assign force_udp = (skip_cnt == SKW'(MAX_SKIP)) && pending_q[SRC_UDP];
  assign do_grant  = (state == IDLE) && win_vld;
  assign win_oh    = do_grant ? (NUM_SRC'(1) << win_idx) : '0;
  assign wd_exp    = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  eth_tx_sched_prio u_prio (
    .pending   (pending_q),
    .force_udp (force_udp),
    .win_idx   (win_idx),
    .win_vld   (win_vld)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      pending_q  <= '0;
      grant_q    <= '0;
      tx_sel_q   <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      skip_cnt   <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      // A new pulse on the granted source survives the clear.
      pending_q  <= (pending_q & ~win_oh) | sif.req_pulse;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;

      if (do_grant && (win_idx != 2'(SRC_UDP)) && pending_q[SRC_UDP]) begin
        if (skip_cnt != SKW'(MAX_SKIP)) skip_cnt <= skip_cnt + SKW'(1);
      end else if ((do_grant && (win_idx == 2'(SRC_UDP))) || !pending_q[SRC_UDP]) begin
        skip_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (win_vld) begin
            state      <= BUSY;
            tx_sel_q   <= win_idx;
            grant_q    <= win_oh;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            to_cnt     <= '0;
          end
        end
        BUSY: begin
          to_cnt <= to_cnt + TW'(1);
          if (sif.tx_done || wd_exp) begin
            // Completion on the expiry cycle still counts as a clean end.
            timeout_q <= !sif.tx_done;
            grant_q   <= '0;
            gap_cnt   <= '0;
            if (IFG_CYCLES == 0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GW'(IFG_CYCLES - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.tx_start    = tx_start_q;
  assign sif.tx_sel      = tx_sel_q;
  assign sif.grant       = grant_q;
  assign sif.pending     = pending_q;
  assign sif.busy        = busy_q;
  assign sif.timeout_err = timeout_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed scenarios plus random traffic, checked every cycle against a timeline model.
module tb_eth_tx_sched;
  import eth_tx_sched_pkg::*;

  localparam int IFG  = 12;
  localparam int TMO  = 4096;
  localparam int MAXS = 4;

  logic aclk;
  logic aresetn;
  eth_tx_sched_if sif ();

  eth_tx_sched #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO), .MAX_SKIP(MAXS)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .sif     (sif)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: frames as time intervals; free_at is the first cycle a grant may be decided.
  logic [3:0] m_pend;
  int         m_skip, m_start, m_free, m_busy_until;
  bit         m_active;
  logic [1:0] m_sel;
  logic       e_start, e_busy, e_to;
  logic [3:0] e_grant, e_pend;
  logic [1:0] e_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] p, input int skip);
    if (skip == MAXS && p[3]) return 3;
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] req, input logic done, input logic rstn);
    int   w;
    logic to;
    if (!rstn) begin
      m_pend = '0; m_skip = 0; m_active = 0; m_free = cyc + 1; m_busy_until = -1; m_sel = '0;
      e_start = 0; e_busy = 0; e_to = 0; e_grant = '0; e_pend = '0; e_sel = '0;
      return;
    end
    to = 1'b0;
    w  = -1;
    if (m_active) begin
      if (done || (cyc - m_start == TMO - 1)) begin
        m_active     = 0;
        to           = !done;
        m_free       = cyc + IFG + 1;
        m_busy_until = cyc + IFG;
      end
    end else if (cyc >= m_free) begin
      w = pick(m_pend, m_skip);
    end
    if (w >= 0 && w != 3 && m_pend[3]) m_skip = (m_skip < MAXS) ? m_skip + 1 : MAXS;
    else if (w == 3 || !m_pend[3])     m_skip = 0;
    if (w >= 0) begin
      m_pend[w] = 1'b0;
      m_active  = 1;
      m_start   = cyc + 1;
      m_sel     = w[1:0];
    end
    m_pend  = m_pend | req;
    e_start = (w >= 0);
    e_sel   = m_sel;
    e_grant = m_active ? (4'b0001 << m_sel) : 4'b0000;
    e_busy  = m_active || (cyc + 1 <= m_busy_until);
    e_to    = to;
    e_pend  = m_pend;
  endtask

  task automatic compare_all();
    check("tx_start", 32'(sif.tx_start), 32'(e_start));
    check("tx_sel", 32'(sif.tx_sel), 32'(e_sel));
    check("grant", 32'(sif.grant), 32'(e_grant));
    check("pending", 32'(sif.pending), 32'(e_pend));
    check("busy", 32'(sif.busy), 32'(e_busy));
    check("timeout_err", 32'(sif.timeout_err), 32'(e_to));
    check("skip_cnt", 32'(dut.skip_cnt), 32'(m_skip));
  endtask

  // Drive one cycle of inputs from a negedge, then sample the next cycle's outputs.
  task automatic step(input logic [3:0] req, input logic done, input logic rstn);
    sif.req_pulse = req;
    sif.tx_done   = done;
    aresetn       = rstn;
    model_step(req, done, rstn);
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic wait_start(output int sel, output int at);
    int n = 0;
    while (sif.tx_start !== 1'b1 && n < 300) begin
      step(4'b0000, 1'b0, 1'b1);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL start_wait at cycle %0d: no tx_start within 300 cycles", cyc);
    end
    sel = 32'(sif.tx_sel);
    at  = cyc;
  endtask

  task automatic finish_frame(input int start, input int len);
    run_to(start + len - 1);
    step(4'b0000, 1'b1, 1'b1);
  endtask

  initial begin
    int sel, s, s2;
    int exp_sel [3] = '{SRC_ARP_RESP, SRC_ARP_REQ, SRC_UDP};
    int exp_pnd [3] = '{4'b1100, 4'b1000, 4'b0000};
    int exp_skp [3] = '{1, 2, 0};
    logic [3:0] rq;
    logic       dn, rn;

    sif.req_pulse = '0;
    sif.tx_done   = 1'b0;
    aresetn       = 1'b0;
    @(negedge aclk);
    cyc = 0;
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("rst_busy", 32'(sif.busy), 0);
    check("rst_pending", 32'(sif.pending), 0);

    // Single ARP response, done at 60; a later ICMP request lands at 74.
    run_to(10);
    step(4'b0001, 1'b0, 1'b1);
    check("pend_n1", 32'(sif.pending), 32'h1);
    step(4'b0000, 1'b0, 1'b1);
    check("start_12", 32'(sif.tx_start), 1);
    check("grant_12", 32'(sif.grant), 32'h1);
    check("sel_12", 32'(sif.tx_sel), 0);
    run_to(60);
    step(4'b0000, 1'b1, 1'b1);
    run_to(65);
    step(4'b0010, 1'b0, 1'b1);
    run_to(72);
    check("busy_72", 32'(sif.busy), 1);
    idle(1);
    check("busy_73", 32'(sif.busy), 0);
    idle(1);
    check("start_74", 32'(sif.tx_start), 1);
    check("sel_74", 32'(sif.tx_sel), SRC_ICMP);
    finish_frame(74, 5);
    idle(14);

    // Simultaneous ARP resp, ARP req and UDP: served 0, 2, 3.
    step(4'b1101, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_start(sel, s);
      check("order_sel", 32'(sel), 32'(exp_sel[k]));
      check("order_pend", 32'(sif.pending), 32'(exp_pnd[k]));
      check("order_skip", 32'(dut.skip_cnt), 32'(exp_skp[k]));
      finish_frame(s, 20);
    end
    idle(14);

    // ARP resp re-posted every frame: UDP still wins the fifth grant.
    step(4'b1001, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_start(sel, s);
      if (k < 4) begin
        check("starve_arp", 32'(sel), SRC_ARP_RESP);
        step(4'b0001, 1'b0, 1'b1);
      end else begin
        check("starve_udp", 32'(sel), SRC_UDP);
        check("starve_p0", 32'(sif.pending[0]), 1);
      end
      finish_frame(s, 10);
    end
    wait_start(sel, s);
    finish_frame(s, 6);
    idle(14);

    // Watchdog: no done, abandon after the 4096th BUSY cycle, no re-grant.
    step(4'b0100, 1'b0, 1'b1);
    wait_start(sel, s);
    run_to(s + TMO);
    check("wd_err", 32'(sif.timeout_err), 1);
    check("wd_grant", 32'(sif.grant), 0);
    check("wd_busy", 32'(sif.busy), 1);
    idle(30);
    check("wd_idle", 32'(sif.busy), 0);
    check("wd_pend", 32'(sif.pending), 0);

    // Re-pulse on the grant edge, then done coincident with expiry.
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    s = cyc;
    check("coin_start", 32'(sif.tx_start), 1);
    check("coin_pend", 32'(sif.pending), 32'h2);
    run_to(s + TMO - 1);
    step(4'b0000, 1'b1, 1'b1);
    check("coin_noerr", 32'(sif.timeout_err), 0);
    check("coin_gap", 32'(sif.busy), 1);
    wait_start(sel, s2);
    check("coin_second", 32'(sel), SRC_ICMP);
    finish_frame(s2, 8);
    idle(14);

    // Reset mid-BUSY with pending 1010, then a stray done.
    step(4'b0001, 1'b0, 1'b1);
    wait_start(sel, s);
    step(4'b1010, 1'b0, 1'b1);
    check("rb_pend", 32'(sif.pending), 32'hA);
    step(4'b0000, 1'b0, 1'b0);
    check("rb_start", 32'(sif.tx_start), 0);
    check("rb_grant", 32'(sif.grant), 0);
    check("rb_pend0", 32'(sif.pending), 0);
    check("rb_busy", 32'(sif.busy), 0);
    check("rb_sel", 32'(sif.tx_sel), 0);
    check("rb_to", 32'(sif.timeout_err), 0);
    step(4'b0000, 1'b1, 1'b1);
    idle(20);
    check("rb_stray", 32'(sif.busy), 0);

    // Random traffic, stray dones and occasional resets.
    repeat (6000) begin
      rq = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      dn = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 2999) != 0);
      step(rq, dn, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
